// File: rtl/arb2_rr.sv
// ---------------------------------------------------------------------------
// arb2_rr : two-source round-robin arbiter feeding a one-entry output slice
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb2_rr #(
    parameter int DWIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid0,
    input  logic [DWIDTH-1:0] i_data0,
    output logic              o_ready0,
    input  logic              i_valid1,
    input  logic [DWIDTH-1:0] i_data1,
    output logic              o_ready1,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_sel,
    input  logic              i_ready
);

    logic              r_prio;
    logic              r_valid;
    logic [DWIDTH-1:0] r_data;
    logic              r_sel;

    logic              w_slot_free;
    logic              w_gnt;
    logic              w_accept;
    logic [DWIDTH-1:0] w_gnt_data;

    // With no contention the lone requester wins; the value with no requester is unused.
    assign w_slot_free = !r_valid || i_ready;
    assign w_gnt       = (i_valid0 && i_valid1) ? r_prio : i_valid1;
    assign w_gnt_data  = w_gnt ? i_data1 : i_data0;

    assign o_ready0 = w_slot_free && i_valid0 && !w_gnt;
    assign o_ready1 = w_slot_free && i_valid1 &&  w_gnt;
    assign w_accept = o_ready0 || o_ready1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_gnt_data;
            r_sel   <= w_gnt;
            r_prio  <= ~w_gnt;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sel   = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_arb2_rr.sv
// ---------------------------------------------------------------------------
// tb_arb2_rr : directed self-checking bench for arb2_rr
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arb2_rr;

    localparam int DWIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid0, valid1, ready;
    logic [DWIDTH-1:0] data0, data1;
    logic              ready0, ready1, o_valid, o_sel;
    logic [DWIDTH-1:0] o_data;

    int n_tests = 0;
    int n_fail  = 0;

    arb2_rr #(.DWIDTH(DWIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid0(valid0),
        .i_data0 (data0),
        .o_ready0(ready0),
        .i_valid1(valid1),
        .i_data1 (data1),
        .o_ready1(ready1),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .i_ready (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
        check({tag, ".data"},  {24'd0, o_data},  {24'd0, d});
        check({tag, ".sel"},   {31'd0, o_sel},   {31'd0, s});
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, ".ready0"}, {31'd0, ready0}, {31'd0, r0});
        check({tag, ".ready1"}, {31'd0, ready1}, {31'd0, r1});
    endtask

    initial begin
        rst = 1'b1; valid0 = 0; valid1 = 0; ready = 0; data0 = 0; data1 = 0;
        #1;
        // Reset state
        @(negedge clk);
        check_out("reset", 1'b0, 8'h00, 1'b0);
        check("reset.prio", {31'd0, dut.r_prio}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Single source from reset
        valid0 = 1; data0 = 8'h3C; ready = 1;
        @(negedge clk);
        check_rdy("single.c0", 1'b1, 1'b0);
        next_cycle();
        valid0 = 0;
        @(negedge clk);
        check_out("single.c1", 1'b1, 8'h3C, 1'b0);
        check("single.prio", {31'd0, dut.r_prio}, 32'd1);

        // Asynchronous reset mid-cycle while holding a beat
        ready = 0;
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 1'b0);
        next_cycle();
        rst = 1'b0;
        ready = 1;
        @(negedge clk);
        check_rdy("idle", 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_out("idle.after", 1'b0, 8'h00, 1'b0);
        check_rdy("idle.after", 1'b0, 1'b0);

        // Contention alternation
        do_reset();
        valid0 = 1; valid1 = 1; data0 = 8'hA0; data1 = 8'hB1; ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_rdy($sformatf("alt.g%0d", i), (i % 2) == 0, (i % 2) == 1);
            if (i > 0)
                check_out($sformatf("alt.o%0d", i - 1), 1'b1,
                          ((i - 1) % 2 == 0) ? 8'hA0 : 8'hB1, ((i - 1) % 2) == 1);
            next_cycle();
        end
        valid0 = 0; valid1 = 0;
        @(negedge clk);
        check_out("alt.o5", 1'b1, 8'hB1, 1'b1);

        // Backpressure
        do_reset();
        valid0 = 1; valid1 = 1; data0 = 8'h55; data1 = 8'h66; ready = 1;
        next_cycle();
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out($sformatf("stall%0d", i), 1'b1, 8'h55, 1'b0);
            check_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
            check($sformatf("stall%0d.prio", i), {31'd0, dut.r_prio}, 32'd1);
            next_cycle();
        end
        ready = 1;
        @(negedge clk);
        check_rdy("unstall", 1'b0, 1'b1);
        next_cycle();
        valid0 = 0; valid1 = 0;
        @(negedge clk);
        check_out("unstall.o", 1'b1, 8'h66, 1'b1);

        // Pointer moves after an uncontended win
        do_reset();
        valid1 = 1; data1 = 8'h11; ready = 1;
        @(negedge clk);
        check_rdy("ptr.c0", 1'b0, 1'b1);
        next_cycle();
        valid0 = 1; data0 = 8'h22;
        @(negedge clk);
        check_out("ptr.o0", 1'b1, 8'h11, 1'b1);
        check_rdy("ptr.c1", 1'b1, 1'b0);
        next_cycle();
        valid0 = 0; valid1 = 0;
        @(negedge clk);
        check_out("ptr.o1", 1'b1, 8'h22, 1'b0);

        // Drain keeps last data and select
        next_cycle();
        valid0 = 1; data0 = 8'h7E;
        @(negedge clk);
        check_rdy("drain.c0", 1'b1, 1'b0);
        next_cycle();
        valid0 = 0;
        @(negedge clk);
        check_out("drain.o0", 1'b1, 8'h7E, 1'b0);
        check_rdy("drain.c1", 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_out("drain.o1", 1'b0, 8'h7E, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
